// File: rtl/lvds_check_pkg.sv
// rtl/lvds_check_pkg.sv - shared types and defaults for the LVDS channel scanner
package lvds_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DWELL,
    SAMPLE,
    SWITCH
  } scan_state_e;

  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int DWELL_CYCLES_DEF  = 400;
  localparam int DEBOUNCE_DEF      = 3;
  localparam int N_CH              = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lvds_debounce.sv
// rtl/lvds_debounce.sv - per-channel visit debouncer with a health-fall pulse
module lvds_debounce
  import lvds_check_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk_fpga,
  input  logic rst_n,
  input  logic update,
  input  logic result,
  output logic ok,
  output logic fall
);

  localparam int              CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    ok_d   = ok_q;
    fall_d = 1'b0;
    if (update) begin
      if (result == ok_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        ok_d   = ~ok_q;
        cnt_d  = '0;
        fall_d = ok_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ok_q   <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
      fall_q <= fall_d;
    end
  end

  assign ok   = ok_q;
  assign fall = fall_q;

endmodule

// File: rtl/lvds_channel_scanner.sv
// rtl/lvds_channel_scanner.sv - alternates the checked LVDS channel, qualifies
// each visit and keeps debounced health plus sticky fault flags
module lvds_channel_scanner
  import lvds_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DWELL_CYCLES  = DWELL_CYCLES_DEF,
  parameter int DEBOUNCE      = DEBOUNCE_DEF
) (
  input  logic       clk_fpga,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] status_in,
  input  logic       clear_faults,
  output logic       choose_channel,
  output logic [1:0] ch_ok,
  output logic [1:0] fault_sticky,
  output logic       all_ok,
  output logic       scan_done
);

  localparam int            TW          = $clog2(max_int(SETTLE_CYCLES, DWELL_CYCLES) + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL_CYCLES - 1);

  scan_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          visit_q, visit_d;
  logic          ch_q, ch_d;
  logic          done_q, done_d;
  logic [1:0]    fault_q, fault_d;
  logic          all_ok_q;
  logic          update;
  logic [1:0]    ok, fall;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    visit_d = visit_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    update  = 1'b0;
    // Dropping enable abandons the visit: no debounce update, no channel toggle.
    if (!enable && state_q != IDLE) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = SETTLE;
            timer_d = '0;
          end
        end
        SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            state_d = DWELL;
            timer_d = '0;
            visit_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        DWELL: begin
          visit_d = visit_q & status_in[ch_q];
          if (timer_q == DWELL_LAST) begin
            state_d = SAMPLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        SAMPLE: begin
          update  = 1'b1;
          state_d = SWITCH;
        end
        SWITCH: begin
          ch_d    = ~ch_q;
          done_d  = ch_q;
          state_d = SETTLE;
          timer_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_deb
    lvds_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk_fpga(clk_fpga),
      .rst_n   (rst_n),
      .update  (update && (ch_q == 1'(ch))),
      .result  (visit_q),
      .ok      (ok[ch]),
      .fall    (fall[ch])
    );
  end

  // A fall arriving with clear_faults still latches.
  assign fault_d = (clear_faults ? 2'b00 : fault_q) | fall;

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      visit_q  <= 1'b0;
      ch_q     <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 2'b00;
      all_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      visit_q  <= visit_d;
      ch_q     <= ch_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      all_ok_q <= &ok;
    end
  end

  assign choose_channel = ch_q;
  assign ch_ok          = ok;
  assign fault_sticky   = fault_q;
  assign all_ok         = all_ok_q;
  assign scan_done      = done_q;

endmodule

// File: doc/lvds_channel_scanner.md
# lvds_channel_scanner

Sequencer directly downstream of the per-channel LVDS clock checker. It alternates `choose_channel` between the two monitored LVDS clock inputs and waits a settling time after each switch. It then qualifies the checker's `status` bit for the selected channel over a dwell window and debounces the per-visit result into stable per-channel health flags. Falling health latches a sticky fault bit for the host and status logic.

## Interface
Parameters:
- `SETTLE_CYCLES`, 8: cycles ignored after a channel switch while the checker re-qualifies.
- `DWELL_CYCLES`, 400: cycles over which the selected status bit must stay 1 for a good visit.
- `DEBOUNCE`, 3: consecutive visits with the opposite result needed to flip `ch_ok[ch]`. Must be ≥1.

Ports:
- `clk_fpga`, in, 1: 100 MHz system clock, the only clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `enable`, in, 1: scanning enabled.
- `status_in`, in, 2: checker `status`. Bit n is meaningful only while channel n is selected.
- `clear_faults`, in, 1: clears `fault_sticky`, level-sensitive.
- `choose_channel`, out, 1: channel select driven to the checker.
- `ch_ok`, out, 2: debounced per-channel health.
- `fault_sticky`, out, 2: latched health-loss flags.
- `all_ok`, out, 1: registered AND of `ch_ok`.
- `scan_done`, out, 1: one-cycle pulse after both channels have been visited.

## Operation
- Reset values: `choose_channel`=0, `ch_ok`=00, `fault_sticky`=00, `all_ok`=0, `scan_done`=0, FSM in IDLE, all counters 0.
- FSM states:
  - IDLE: waits for `enable`=1, then goes to SETTLE.
  - SETTLE: counts `SETTLE_CYCLES` cycles; `status_in` is ignored.
  - DWELL: counts `DWELL_CYCLES` cycles. The visit flag starts at 1 on entry and is ANDed each cycle with `status_in[choose_channel]`.
  - SAMPLE: 1 cycle; updates the debouncer of the current channel.
  - SWITCH: 1 cycle; toggles `choose_channel`, then goes to SETTLE.
- Debouncer, per channel:
  - If the visit result equals `ch_ok[ch]`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE`, `ch_ok[ch]` flips and the counter clears.
- Fault latch:
  - `fault_sticky[ch]` sets on a 1→0 transition of `ch_ok[ch]` only.
  - `clear_faults` clears both bits; a set in the same cycle wins.
- `scan_done` pulses when SWITCH leaves channel 1.
- If `enable`=0 in any non-IDLE state, go to IDLE on the next edge. The in-progress visit is discarded. `ch_ok` and debounce counters are untouched, and `choose_channel` holds. On re-enable, scanning restarts at SETTLE on the held channel.
- Asynchronous reset mid-operation forces all reset values immediately.
- Counter widths:
  - Timer: `$clog2(max(SETTLE_CYCLES,DWELL_CYCLES)+1)`.
  - Debounce counter: `$clog2(DEBOUNCE+1)`.
  - Counters never wrap; they are reloaded on each state entry.

## Timing
- One channel visit lasts `SETTLE_CYCLES+DWELL_CYCLES+2` cycles: 410 with defaults. A full scan lasts 820 cycles.
- `ch_ok`, `fault_sticky` and `all_ok` update registered. `ch_ok` is visible the cycle after SAMPLE. `all_ok` and `fault_sticky` follow one cycle later.
- `choose_channel` changes the cycle after SWITCH. `scan_done` is high for exactly that cycle when the channel goes from 1 to 0.
- From reset with `enable`=1 and good inputs, `ch_ok[ch]` rises after the `DEBOUNCE`-th visit to that channel: third scan with defaults.
- A single bad cycle anywhere in DWELL makes the whole visit bad. Status glitches during SETTLE have no effect.

## Structure
- Package `lvds_check_pkg`:
  - FSM state enum: IDLE, SETTLE, DWELL, SAMPLE, SWITCH.
  - Default constants `SETTLE_CYCLES_DEF`, `DWELL_CYCLES_DEF`, `DEBOUNCE_DEF`.
  - Channel count `N_CH`=2.
- Sub-module `lvds_debounce`, instantiated once per channel.
  - Inputs: `clk_fpga`, `rst_n`, `update` strobe, `result`.
  - Outputs: `ok`, plus a `fall` pulse used by the fault latch.

## Test plan
- Reset and idle: `rst_n`=0, then release with `enable`=0. All outputs stay 0 and `choose_channel` stays 0 for 2000 cycles.
- Both channels good, defaults: `status_in`=11, `enable`=1.
  - `scan_done` pulses every 820 cycles.
  - `ch_ok` becomes 01, then 11, during the third scan; `all_ok`=1 one cycle after `ch_ok`=11.
  - `fault_sticky` stays 00.
- Glitch rejection: with `ch_ok`=11, drop `status_in[1]` for 1 cycle inside one channel-1 DWELL, then restore. `ch_ok` stays 11, `fault_sticky` stays 00, and the debounce counter returns to 0 on the next good visit.
- Channel loss and recovery: hold `status_in[1]`=0 for 3 channel-1 visits.
  - `ch_ok[1]` falls after the 3rd SAMPLE, and `fault_sticky[1]`=1 and `all_ok`=0 follow one cycle later.
  - After restoring, `ch_ok[1]` returns after 3 good visits; `fault_sticky[1]` stays 1 until `clear_faults`.
- `clear_faults` asserted in the same cycle as a `ch_ok[0]` fall: `fault_sticky[0]` ends at 1.
- Mid-dwell interruptions:
  - Drop `enable` at cycle 200 of a channel-0 DWELL: FSM goes to IDLE, `choose_channel` holds 0, `ch_ok` is unchanged. Re-enable restarts SETTLE on channel 0.
  - Assert `rst_n`=0 mid-DWELL: all outputs are 0 immediately, without waiting for a clock edge.
